arm_banked_regfile: RTL and testbench

//  ARMv4 register file with banked registers per processor mode, NUM_RD read ports, two write ports,
//  PC auto-increment and a post-reset clear sweep. Replaces the flat 16-entry bank.

---
 rtl/arm_banked_regfile.sv | 216 +++++++++++++++++++++
 tb/tb_arm_banked_regfile.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_banked_regfile.sv
// ARMv4 banked register file: 31 physical registers mapped per processor mode, NUM_RD combinational
// read ports, two write ports (A wins on collision), PC auto-increment and a post-reset clear sweep.
module arm_banked_regfile #(
   parameter int                DATA_W      = 32,
   parameter int                NUM_RD      = 3,
   parameter logic [DATA_W-1:0] SP_RESET    = 32'h0000_8000,
   parameter logic [DATA_W-1:0] PC_RESET    = 32'h0000_0000,
   parameter int                PC_STEP     = 4,
   parameter int                CLEAR_SWEEP = 1,
   parameter int                BYPASS      = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [4:0]               mode,
   input  logic                     usr_bank,
   input  logic [NUM_RD*4-1:0]      rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wa_en,
   input  logic [3:0]               wa_addr,
   input  logic [DATA_W-1:0]        wa_data,
   input  logic                     wb_en,
   input  logic [3:0]               wb_addr,
   input  logic [DATA_W-1:0]        wb_data,
   input  logic                     pc_inc,
   output logic [DATA_W-1:0]        pc,
   output logic [DATA_W-1:0]        sp,
   output logic                     busy,
   output logic                     mode_err
);

   localparam int NUM_PHYS = 31;

   typedef enum logic [2:0] {BK_USR, BK_FIQ, BK_IRQ, BK_SVC, BK_ABT, BK_UND} bank_e;
   typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_IDLE} state_e;

   function automatic logic mode_legal(input logic [4:0] m);
      logic ok;
      case (m)
         5'b10000, 5'b10001, 5'b10010, 5'b10011,
         5'b10111, 5'b11011, 5'b11111: ok = 1'b1;
         default:                      ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Illegal modes and usr_bank both fall back to the user bank.
   function automatic bank_e bank_of(input logic [4:0] m, input logic ub);
      bank_e b;
      if (ub) begin
         b = BK_USR;
      end else begin
         case (m)
            5'b10001: b = BK_FIQ;
            5'b10010: b = BK_IRQ;
            5'b10011: b = BK_SVC;
            5'b10111: b = BK_ABT;
            5'b11011: b = BK_UND;
            default:  b = BK_USR;
         endcase
      end
      return b;
   endfunction

   // Physical layout: 0-15 user, 16-22 fiq r8-r14, then r13/r14 pairs for IRQ, SVC, ABT, UND.
   function automatic logic [4:0] phys_of(input logic [3:0] a, input bank_e b);
      logic [4:0] p;
      logic [4:0] base;
      case (b)
         BK_IRQ:  base = 5'd23;
         BK_SVC:  base = 5'd25;
         BK_ABT:  base = 5'd27;
         BK_UND:  base = 5'd29;
         default: base = 5'd23;
      endcase
      if (b == BK_FIQ && a >= 4'd8 && a <= 4'd14) begin
         p = {1'b0, a} + 5'd8;
      end else if (b inside {BK_IRQ, BK_SVC, BK_ABT, BK_UND} && (a == 4'd13 || a == 4'd14)) begin
         p = base + {4'd0, ~a[0]};
      end else begin
         p = {1'b0, a};
      end
      return p;
   endfunction

   function automatic logic [DATA_W-1:0] reset_val(input logic [4:0] i);
      logic [DATA_W-1:0] v;
      case (i)
         5'd13, 5'd21, 5'd23, 5'd25, 5'd27, 5'd29: v = SP_RESET;
         5'd15:                                    v = PC_RESET;
         default:                                  v = '0;
      endcase
      return v;
   endfunction

   function automatic logic is_ctrl_reg(input logic [4:0] i);
      logic r;
      case (i)
         5'd13, 5'd21, 5'd23, 5'd25, 5'd27, 5'd29,
         5'd14, 5'd22, 5'd24, 5'd26, 5'd28, 5'd30, 5'd15: r = 1'b1;
         default:                                         r = 1'b0;
      endcase
      return r;
   endfunction

   logic [DATA_W-1:0] regs_q [NUM_PHYS];
   logic [DATA_W-1:0] regs_d [NUM_PHYS];
   state_e            state_q, state_d;
   logic [4:0]        idx_q, idx_d;
   logic              busy_q, busy_d;

   bank_e             bank_s;
   logic [4:0]        pa_s, pb_s, sp_idx_s;
   logic              wr_ok_s;
   logic [DATA_W-1:0] pc_next_s;
   logic [4:0]        rd_phys_s;
   logic [DATA_W-1:0] rd_val_s;

   assign bank_s    = bank_of(mode, usr_bank);
   assign pa_s      = phys_of(wa_addr, bank_s);
   assign pb_s      = phys_of(wb_addr, bank_s);
   assign sp_idx_s  = phys_of(4'd13, bank_s);
   assign wr_ok_s   = (state_q == ST_IDLE) && !rst;
   assign pc_next_s = regs_q[15] + DATA_W'(PC_STEP);

   // Next-state: reset, clear sweep (the RESET cycle already clears index 0), or normal writes.
   always_comb begin
      regs_d  = regs_q;
      state_d = state_q;
      idx_d   = idx_q;
      if (rst) begin
         for (int i = 0; i < NUM_PHYS; i++) begin
            if (is_ctrl_reg(5'(i))) begin
               regs_d[i] = reset_val(5'(i));
            end else begin
               regs_d[i] = regs_q[i];
            end
         end
         state_d = ST_RESET;
         idx_d   = 5'd0;
      end else begin
         case (state_q)
            ST_RESET, ST_CLEAR: begin
               if (CLEAR_SWEEP != 0) begin
                  regs_d[idx_q] = reset_val(idx_q);
                  idx_d         = idx_q + 5'd1;
                  state_d       = (idx_q == 5'd30) ? ST_IDLE : ST_CLEAR;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (pc_inc) begin
                  regs_d[15] = pc_next_s;
               end else begin
                  regs_d[15] = regs_q[15];
               end
               if (wb_en) begin
                  regs_d[pb_s] = wb_data;
               end else begin
                  regs_d[pb_s] = regs_d[pb_s];
               end
               // Port A applied last so it overrides both port B and pc_inc.
               if (wa_en) begin
                  regs_d[pa_s] = wa_data;
               end else begin
                  regs_d[pa_s] = regs_d[pa_s];
               end
            end
            default: begin
               state_d = ST_RESET;
               idx_d   = 5'd0;
            end
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   // Read ports with optional same-cycle bypass of the winning write.
   always_comb begin
      rd_data   = '0;
      rd_phys_s = 5'd0;
      rd_val_s  = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         rd_phys_s = phys_of(rd_addr[4*p +: 4], bank_s);
         rd_val_s  = regs_q[rd_phys_s];
         if (BYPASS != 0 && wr_ok_s) begin
            if (wa_en && pa_s == rd_phys_s) begin
               rd_val_s = wa_data;
            end else if (wb_en && pb_s == rd_phys_s) begin
               rd_val_s = wb_data;
            end else if (pc_inc && rd_phys_s == 5'd15) begin
               rd_val_s = pc_next_s;
            end else begin
               rd_val_s = regs_q[rd_phys_s];
            end
         end else begin
            rd_val_s = regs_q[rd_phys_s];
         end
         rd_data[p*DATA_W +: DATA_W] = rd_val_s;
      end
   end

   // State and register storage.
   always_ff @(posedge clk) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      regs_q  <= regs_d;
   end

   assign pc       = regs_q[15];
   assign sp       = regs_q[sp_idx_s];
   assign busy     = busy_q;
   assign mode_err = !mode_legal(mode);

endmodule

// File: tb/tb_arm_banked_regfile.sv
// Randomised bench for arm_banked_regfile: an architectural per-bank model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_arm_banked_regfile;

   localparam logic [4:0] M_USR = 5'b10000, M_FIQ = 5'b10001, M_IRQ = 5'b10010,
                          M_SVC = 5'b10011, M_ABT = 5'b10111, M_UND = 5'b11011, M_SYS = 5'b11111;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  mode;
   logic        usr_bank;
   logic [11:0] rd_addr;
   logic [95:0] rd_data;
   logic        wa_en, wb_en, pc_inc;
   logic [3:0]  wa_addr, wb_addr;
   logic [31:0] wa_data, wb_data;
   logic [31:0] pc, sp;
   logic        busy, mode_err;

   arm_banked_regfile dut (
      .clk(clk), .rst(rst), .mode(mode), .usr_bank(usr_bank),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .pc_inc(pc_inc), .pc(pc), .sp(sp), .busy(busy), .mode_err(mode_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Architectural model: bank 0 usr, 1 fiq, 2 irq, 3 svc, 4 abt, 5 und
   logic [31:0] m_usr [16];
   logic [31:0] m_fiq [7];
   logic [31:0] m_b13 [6];
   logic [31:0] m_b14 [6];
   int          m_busy_left = 0;
   bit          m_valid = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int bank_m(input logic [4:0] m, input logic ub);
      if (ub) return 0;
      case (m)
         M_FIQ:   return 1;
         M_IRQ:   return 2;
         M_SVC:   return 3;
         M_ABT:   return 4;
         M_UND:   return 5;
         default: return 0;
      endcase
   endfunction

   function automatic bit legal_m(input logic [4:0] m);
      return m inside {M_USR, M_FIQ, M_IRQ, M_SVC, M_ABT, M_UND, M_SYS};
   endfunction

   function automatic logic [31:0] get_m(input int b, input logic [3:0] a);
      if (a < 4'd8 || a == 4'd15) return m_usr[a];
      if (b == 1) return m_fiq[a - 4'd8];
      if (b >= 2 && a == 4'd13) return m_b13[b];
      if (b >= 2 && a == 4'd14) return m_b14[b];
      return m_usr[a];
   endfunction

   task automatic set_m(input int b, input logic [3:0] a, input logic [31:0] v);
      if (a < 4'd8 || a == 4'd15) m_usr[a] = v;
      else if (b == 1) m_fiq[a - 4'd8] = v;
      else if (b >= 2 && a == 4'd13) m_b13[b] = v;
      else if (b >= 2 && a == 4'd14) m_b14[b] = v;
      else m_usr[a] = v;
   endtask

   // After the full reset sequence every register holds its reset value.
   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_usr[i] = 32'h0;
      m_usr[13] = 32'h8000;
      for (int i = 0; i < 7; i++) m_fiq[i] = 32'h0;
      m_fiq[5] = 32'h8000;
      for (int i = 0; i < 6; i++) begin
         m_b13[i] = 32'h8000;
         m_b14[i] = 32'h0;
      end
      m_busy_left = 31;
      m_valid     = 1;
   endtask

   task automatic model_step();
      int b;
      b = bank_m(mode, usr_bank);
      if (rst) begin
         model_reset();
      end else if (m_busy_left > 0) begin
         m_busy_left--;
      end else begin
         if (pc_inc) m_usr[15] = m_usr[15] + 32'd4;
         if (wb_en) set_m(b, wb_addr, wb_data);
         if (wa_en) set_m(b, wa_addr, wa_data);
      end
   endtask

   function automatic logic [31:0] read_m(input logic [3:0] a);
      int b;
      b = bank_m(mode, usr_bank);
      if (wa_en && wa_addr == a) return wa_data;
      if (wb_en && wb_addr == a) return wb_data;
      if (pc_inc && a == 4'd15) return m_usr[15] + 32'd4;
      return get_m(b, a);
   endfunction

   task automatic compare_all();
      int b;
      if (!m_valid || rst) return;
      b = bank_m(mode, usr_bank);
      chk("busy", {31'd0, busy}, {31'd0, m_busy_left != 0});
      chk("mode_err", {31'd0, mode_err}, {31'd0, !legal_m(mode)});
      chk("pc", pc, m_usr[15]);
      chk("sp", sp, get_m(b, 4'd13));
      if (m_busy_left == 0) begin
         for (int p = 0; p < 3; p++) begin
            chk($sformatf("rd%0d_r%0d", p, rd_addr[4*p +: 4]), rd_data[32*p +: 32],
                read_m(rd_addr[4*p +: 4]));
         end
      end
   endtask

   // One cycle: check outputs mid-cycle, advance the model at the edge, resume after the edge.
   task automatic tick();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic wr_a(input logic [4:0] m, input logic ub, input logic [3:0] a, input logic [31:0] d);
      mode = m; usr_bank = ub; wa_en = 1'b1; wa_addr = a; wa_data = d;
      tick();
      wa_en = 1'b0; usr_bank = 1'b0;
   endtask

   task automatic rd_p(input logic [4:0] m, input logic ub, input logic [3:0] a, output logic [31:0] v);
      tick();
      wa_en = 1'b0; wb_en = 1'b0; pc_inc = 1'b0;
      mode = m; usr_bank = ub; rd_addr[3:0] = a;
      #1;
      v = rd_data[31:0];
   endtask

   task automatic busy_len(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         tick();
      end
   endtask

   initial begin
      logic [31:0] v;
      int          n;
      rst = 1'b1; mode = M_USR; usr_bank = 1'b0; rd_addr = 12'h0;
      wa_en = 1'b0; wb_en = 1'b0; pc_inc = 1'b0;
      wa_addr = 4'd0; wb_addr = 4'd0; wa_data = 32'h0; wb_data = 32'h0;
      tick();
      rst = 1'b0;

      // Reset sweep length, plus a write during busy that must not land.
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         wa_en = (n == 5); wa_addr = 4'd0; wa_data = 32'hDEAD_0000;
         n++;
         tick();
      end
      wa_en = 1'b0;
      chk("busy_len_reset", n, 32'd31);
      rd_p(M_USR, 1'b0, 4'd0, v);  chk("usr_r0_after_busy_write", v, 32'h0);
      rd_p(M_USR, 1'b0, 4'd13, v); chk("usr_r13_reset", v, 32'h8000);
      rd_p(M_USR, 1'b0, 4'd15, v); chk("usr_r15_reset", v, 32'h0);
      chk("pc_reset", pc, 32'h0);

      // Banking of r13 and sharing of r8 between USR and SVC.
      wr_a(M_USR, 1'b0, 4'd13, 32'h1111);
      wr_a(M_SVC, 1'b0, 4'd13, 32'h2222);
      wr_a(M_SVC, 1'b0, 4'd8, 32'h33);
      rd_p(M_SVC, 1'b0, 4'd13, v); chk("svc_r13", v, 32'h2222);
      chk("svc_sp", sp, 32'h2222);
      rd_p(M_USR, 1'b0, 4'd13, v); chk("usr_r13", v, 32'h1111);
      rd_p(M_USR, 1'b0, 4'd8, v);  chk("usr_r8", v, 32'h33);
      rd_p(M_FIQ, 1'b0, 4'd8, v);  chk("fiq_r8", v, 32'h0);

      // Port collision: A wins, also on the bypass path.
      tick();
      mode = M_USR; wa_en = 1'b1; wa_addr = 4'd5; wa_data = 32'hAA;
      wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'hBB; rd_addr[3:0] = 4'd5;
      #1; chk("bypass_a_over_b", rd_data[31:0], 32'hAA);
      tick();
      wa_en = 1'b0; wb_en = 1'b0;
      rd_p(M_USR, 1'b0, 4'd5, v); chk("r5_a_over_b", v, 32'hAA);

      // A write to r15 overrides pc_inc.
      wa_en = 1'b1; wa_addr = 4'd15; wa_data = 32'h100; pc_inc = 1'b1;
      tick();
      wa_en = 1'b0; pc_inc = 1'b0;
      chk("pc_write_over_inc", pc, 32'h100);

      // PC wraps; the bypassed r15 read already shows the wrapped value.
      wr_a(M_USR, 1'b0, 4'd15, 32'hFFFF_FFFC);
      pc_inc = 1'b1; rd_addr[3:0] = 4'd15;
      #1; chk("pc_wrap_bypass", rd_data[31:0], 32'h0);
      chk("pc_before_wrap", pc, 32'hFFFF_FFFC);
      tick();
      pc_inc = 1'b0;
      chk("pc_wrapped", pc, 32'h0);

      // usr_bank from FIQ targets the user copy of r10.
      wr_a(M_FIQ, 1'b1, 4'd10, 32'h55);
      rd_p(M_USR, 1'b0, 4'd10, v); chk("usr_r10_via_usr_bank", v, 32'h55);
      rd_p(M_FIQ, 1'b0, 4'd10, v); chk("fiq_r10_untouched", v, 32'h0);
      rd_p(5'b00000, 1'b0, 4'd13, v);
      chk("illegal_mode_err", {31'd0, mode_err}, 32'd1);
      chk("illegal_mode_usr_r13", v, 32'h1111);
      rd_p(M_SYS, 1'b0, 4'd13, v);
      chk("sys_mode_err", {31'd0, mode_err}, 32'd0);

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 9))
            0: mode = M_USR;  1: mode = M_FIQ;  2: mode = M_IRQ;  3: mode = M_SVC;
            4: mode = M_ABT;  5: mode = M_UND;  6: mode = M_SYS;  7: mode = M_FIQ;
            8: mode = 5'($urandom);
            default: mode = M_SVC;
         endcase
         usr_bank = ($urandom_range(0, 7) == 0);
         rd_addr  = 12'($urandom);
         wa_en    = ($urandom_range(0, 2) != 0);
         wa_addr  = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(8, 14));
         wa_data  = $urandom;
         wb_en    = ($urandom_range(0, 2) == 0);
         wb_addr  = ($urandom_range(0, 3) == 0) ? wa_addr : 4'($urandom);
         wb_data  = $urandom;
         pc_inc   = ($urandom_range(0, 1) == 1);
         tick();
      end
      wa_en = 1'b0; wb_en = 1'b0; pc_inc = 1'b0; usr_bank = 1'b0; mode = M_USR;

      // Reset in the middle of the sweep restarts it from index 0.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (13) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      busy_len(n);
      chk("busy_len_restart", n, 32'd31);
      for (int i = 0; i < 16; i++) begin
         rd_p(M_USR, 1'b0, 4'(i), v);
         chk($sformatf("usr_r%0d_after_restart", i), v, (i == 13) ? 32'h8000 : 32'h0);
      end
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
